// File: rtl/mem_bank_pkg.sv
// Shared types and default geometry for the masked memory bank RW initiator.
// Clients use mem_req_t to bundle a request for one bank port.
package mem_bank_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } init_state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_DATA_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_rsp_buffer.sv
// Single-entry valid/ready holding register. A load in the same cycle as a
// consume replaces the held word and keeps the entry valid.
module mem_rsp_buffer
  import mem_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_reg, valid_next;
  logic [DATA_W-1:0] data_reg, data_next;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (load) begin
      valid_next = 1'b1;
      data_next  = load_data;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/mem_bank_rw_initiator.sv
// Controller for one RW port of a masked memory bank: arbitrates client
// requests against a hardware init sweep and buffers one read response.
module mem_bank_rw_initiator
  import mem_bank_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                DEPTH      = DEF_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              RW_en,
  output logic              RW_wmode,
  output logic [ADDR_W-1:0] RW_addr,
  output logic [DATA_W-1:0] RW_wdata,
  output logic [DATA_W-1:0] RW_wmask,
  input  logic [DATA_W-1:0] RW_rdata
);

  // One extra counter bit so DEPTH == 2**ADDR_W ends without wrapping.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  init_state_e       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              init_done_reg, init_done_next;
  logic [ADDR_W-1:0] addr_shadow_reg;
  logic [DATA_W-1:0] wdata_shadow_reg;

  logic              fire;
  logic              rd_fire;
  logic              en_drv;
  logic              wmode_drv;
  logic [ADDR_W-1:0] addr_drv;
  logic [DATA_W-1:0] wdata_drv;
  logic [DATA_W-1:0] wmask_drv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      init_done_reg    <= 1'b0;
      addr_shadow_reg  <= '0;
      wdata_shadow_reg <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      init_done_reg    <= init_done_next;
      addr_shadow_reg  <= addr_drv;
      wdata_shadow_reg <= wdata_drv;
    end
  end

  // rst gates req_ready so the memory side drops to zero the moment reset rises.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    init_done_next = 1'b0;
    req_ready      = 1'b0;
    fire           = 1'b0;
    en_drv         = 1'b0;
    wmode_drv      = 1'b0;
    addr_drv       = addr_shadow_reg;
    wdata_drv      = wdata_shadow_reg;
    wmask_drv      = '0;
    unique case (state_reg)
      IDLE: begin
        req_ready = !rst && !init_start && (!rsp_valid || rsp_ready);
        fire      = req_valid && req_ready;
        if (fire) begin
          en_drv    = 1'b1;
          wmode_drv = req_write;
          addr_drv  = req_addr;
          wdata_drv = req_wdata;
          wmask_drv = req_wmask;
        end
        if (init_start && !rst) begin
          state_next = INIT;
          cnt_next   = '0;
        end
      end
      INIT: begin
        en_drv    = 1'b1;
        wmode_drv = 1'b1;
        addr_drv  = cnt_reg[ADDR_W-1:0];
        wdata_drv = INIT_VALUE;
        wmask_drv = '1;
        cnt_next  = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_IDX) begin
          state_next     = IDLE;
          init_done_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_fire = fire && !req_write;

  mem_rsp_buffer #(
    .DATA_W(DATA_W)
  ) u_rsp_buffer (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_fire),
    .load_data(RW_rdata),
    .out_valid(rsp_valid),
    .out_ready(rsp_ready),
    .out_data (rsp_rdata)
  );

  assign init_busy = (state_reg == INIT);
  assign init_done = init_done_reg;
  assign RW_en     = en_drv;
  assign RW_wmode  = wmode_drv;
  assign RW_addr   = addr_drv;
  assign RW_wdata  = wdata_drv;
  assign RW_wmask  = wmask_drv;

endmodule

// File: tb/tb_mem_bank_rw_initiator.sv
// Bench for mem_bank_rw_initiator: a bank model, a transaction-level reference
// model compared every cycle, directed scenarios and a randomized phase.
module tb_mem_bank_rw_initiator;

  localparam int AW    = 5;
  localparam int DW    = 10;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_start = 1'b0;
  logic          init_busy, init_done;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          RW_en, RW_wmode;
  logic [AW-1:0] RW_addr;
  logic [DW-1:0] RW_wdata, RW_wmask, RW_rdata;

  always #5 clk = ~clk;

  mem_bank_rw_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_VALUE(10'h000)
  ) dut (
    .clk(clk), .rst(rst),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .RW_en(RW_en), .RW_wmode(RW_wmode), .RW_addr(RW_addr),
    .RW_wdata(RW_wdata), .RW_wmask(RW_wmask), .RW_rdata(RW_rdata)
  );

  function automatic logic [DW-1:0] seed_val(int i);
    return DW'((i * 37 + 11) ^ 'h2B5);
  endfunction

  // Bank: masked synchronous write, combinational read, no reset.
  logic          preload = 1'b1;
  logic [DW-1:0] bank_mem [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) bank_mem[i] <= seed_val(i);
    end else if (RW_en && RW_wmode) begin
      bank_mem[RW_addr] <= (bank_mem[RW_addr] & ~RW_wmask) | (RW_wdata & RW_wmask);
    end
  end
  assign RW_rdata = bank_mem[RW_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit            m_sweep, m_done, m_rvalid;
  int            m_idx;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_sh_addr;
  logic [DW-1:0] m_sh_wdata;
  logic [DW-1:0] m_mem [DEPTH];
  bit            n_sweep, n_done, n_rvalid, n_wr;
  int            n_idx;
  logic [DW-1:0] n_rdata, n_wr_data, n_wr_mask;
  logic [AW-1:0] n_wr_addr;
  bit            e_ready, e_en, e_wm, e_fire;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_mask;
  int            sweep_wr = 0;
  int            done_cnt = 0;

  // Compare DUT against the model every cycle and compute the model's next state.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", init_busy, 0);
      chk("rst_done", init_done, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_mem_side", {RW_en, RW_wmode, RW_addr, RW_wdata, RW_wmask}, 0);
    end else begin
      e_fire = 1'b0;
      if (m_sweep) begin
        e_ready = 0; e_en = 1; e_wm = 1;
        e_addr = AW'(m_idx); e_wd = '0; e_mask = '1;
      end else begin
        e_ready = !init_start && (!m_rvalid || rsp_ready);
        e_fire  = req_valid && e_ready;
        if (e_fire) begin
          e_en = 1; e_wm = req_write; e_addr = req_addr; e_wd = req_wdata; e_mask = req_wmask;
        end else begin
          e_en = 0; e_wm = 0; e_addr = m_sh_addr; e_wd = m_sh_wdata; e_mask = '0;
        end
      end
      chk("init_busy", init_busy, m_sweep);
      chk("init_done", init_done, m_done);
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, m_rvalid);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("RW_en", RW_en, e_en);
      chk("RW_wmode", RW_wmode, e_wm);
      chk("RW_addr", RW_addr, e_addr);
      chk("RW_wdata", RW_wdata, e_wd);
      chk("RW_wmask", RW_wmask, e_mask);
      if (e_fire)
        $display("txn t=%0t %s addr=%0d wdata=0x%h mask=0x%h", $time,
                 req_write ? "WR" : "RD", req_addr, req_wdata, req_wmask);
      if (init_busy && RW_en && RW_wmode) sweep_wr++;
      if (init_done) done_cnt++;

      n_sweep = m_sweep; n_idx = m_idx; n_done = 0;
      n_rvalid = m_rvalid; n_rdata = m_rdata;
      n_wr = e_en && e_wm; n_wr_addr = e_addr; n_wr_data = e_wd; n_wr_mask = e_mask;
      if (m_sweep) begin
        n_idx = m_idx + 1;
        if (n_idx == DEPTH) begin n_sweep = 0; n_done = 1; end
      end else if (init_start) begin
        n_sweep = 1; n_idx = 0;
      end
      if (e_fire && !req_write) begin
        n_rvalid = 1; n_rdata = m_mem[req_addr];
      end else if (rsp_ready) begin
        n_rvalid = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (preload)
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= seed_val(i);
    if (rst) begin
      m_sweep <= 0; m_idx <= 0; m_done <= 0; m_rvalid <= 0;
      m_rdata <= '0; m_sh_addr <= '0; m_sh_wdata <= '0;
    end else begin
      m_sweep <= n_sweep; m_idx <= n_idx; m_done <= n_done;
      m_rvalid <= n_rvalid; m_rdata <= n_rdata;
      m_sh_addr <= n_wr_addr; m_sh_wdata <= n_wr_data;
      if (n_wr)
        m_mem[n_wr_addr] <= (m_mem[n_wr_addr] & ~n_wr_mask) | (n_wr_data & n_wr_mask);
    end
  end

  task automatic do_req(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] m);
    bit ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 0;
    chk("req_accept", ok, 1);
  endtask

  task automatic get_rsp(output logic [DW-1:0] d, output int waited);
    bit ok = 0;
    d = '0; waited = -1;
    rsp_ready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) begin d = rsp_rdata; waited = k; ok = 1; break; end
    end
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("rsp_arrive", ok, 1);
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    int w;
    do_req(0, a, '0, '0);
    get_rsp(d, w);
    chk(name, d, exp);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    int w;
    bit ok;

    repeat (2) @(posedge clk);
    #1 preload = 0;
    @(negedge clk);
    chk("reset_busy", init_busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_RW_en", RW_en, 0);
    @(posedge clk); #1 rst = 0;

    // Full init sweep
    sweep_wr = 0; done_cnt = 0;
    init_start = 1;
    @(posedge clk); #1 init_start = 0;
    wait_done(ok);
    chk("sweep1_done_seen", ok, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("sweep1_writes", sweep_wr, 32);
    chk("sweep1_done_pulses", done_cnt, 1);
    read_chk("post_init_a0", 0, 10'h000);
    read_chk("post_init_a17", 17, 10'h000);
    read_chk("post_init_a31", 31, 10'h000);

    // Write then read next cycle, then masked write
    do_req(1, 5, 10'h2AA, 10'h3FF);
    do_req(0, 5, '0, '0);
    get_rsp(d, w);
    chk("rd5_latency", w, 0);
    chk("rd5_data", d, 10'h2AA);
    do_req(1, 5, 10'h155, 10'h00F);
    read_chk("rd5_masked", 5, 10'h2A5);

    // Backpressure
    do_req(1, 1, 10'h123, 10'h3FF);
    do_req(1, 2, 10'h0F0, 10'h3FF);
    do_req(0, 1, '0, '0);
    req_valid = 1; req_write = 0; req_addr = 2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", req_ready, 0);
      chk("bp_hold_data", rsp_rdata, 10'h123);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_ready_release", req_ready, 1);
    chk("bp_old_data", rsp_rdata, 10'h123);
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    chk("bp_new_valid", rsp_valid, 1);
    chk("bp_new_data", rsp_rdata, 10'h0F0);
    @(posedge clk); #1 rsp_ready = 0;

    // init_start collides with a request; second init_start ignored
    sweep_wr = 0; done_cnt = 0;
    init_start = 1; req_valid = 1; req_write = 0; req_addr = 5; rsp_ready = 1;
    @(negedge clk);
    chk("collide_not_ready", req_ready, 0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      init_start = (k == 5);
      @(negedge clk);
      if (init_done) begin
        ok = 1;
        chk("done_cycle_ready", req_ready, 1);
        break;
      end
    end
    chk("sweep2_done_seen", ok, 1);
    @(posedge clk); #1 req_valid = 0; init_start = 0;
    @(negedge clk);
    chk("done_cycle_rsp_valid", rsp_valid, 1);
    chk("done_cycle_rsp_data", rsp_rdata, 10'h000);
    @(posedge clk); #1 rsp_ready = 0;
    chk("sweep2_writes", sweep_wr, 32);
    chk("sweep2_done_pulses", done_cnt, 1);

    // Reset in the middle of a sweep
    do_req(1, 20, 10'h1C3, 10'h3FF);
    do_req(1, 3, 10'h3FF, 10'h3FF);
    init_start = 1;
    @(posedge clk); #1 init_start = 0;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (init_busy && RW_addr == 10) begin ok = 1; break; end
    end
    chk("sweep3_reached_10", ok, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_en", RW_en, 0);
    chk("async_rst_wmode", RW_wmode, 0);
    chk("async_rst_addr", RW_addr, 0);
    chk("async_rst_busy", init_busy, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_restart_busy", init_busy, 0);
    @(posedge clk); #1;
    for (int a = 0; a < 10; a++) read_chk("partial_low", AW'(a), 10'h000);
    read_chk("partial_a20_kept", 20, 10'h1C3);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 300; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom_range(0, 1));
      req_addr   = AW'($urandom);
      req_wdata  = DW'($urandom);
      req_wmask  = DW'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      init_start = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    req_valid = 0; init_start = 0; rsp_ready = 1;
    repeat (40) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bank_rw_initiator.md
Name: mem_bank_rw_initiator

Overview:
- Initiator/controller for one RW port of a 2rw masked memory bank (default 32 x 10).
- Upstream side: valid/ready request channel and valid/ready read-response channel. Downstream side: drives `RW_en`, `RW_wmode`, `RW_addr`, `RW_wdata` and `RW_wmask`, and samples the bank's combinational `RW_rdata`.
- Also provides a hardware init sweep that writes `INIT_VALUE` to every word.
- One instance per bank port; instances sit between client logic and the bank.

Parameters:
- `ADDR_W`, 5, address width.
- `DATA_W`, 10, data and mask width.
- `DEPTH`, 32, number of words swept by init (must be ≤ 2^`ADDR_W`).
- `INIT_VALUE`, 0, `DATA_W`-bit word written by the init sweep.

Ports:
- `clk` in 1: single clock. Drive the same clock to the bank's `RWn_clk`.
- `rst` in 1: asynchronous, active-high reset.
- `init_start` in 1: one-cycle request to start the init sweep.
- `init_busy` out 1: high while the sweep is running.
- `init_done` out 1: one-cycle pulse when the sweep completes.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid` && `req_ready`.
- `req_write` in 1: 1 = masked write, 0 = read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: write data.
- `req_wmask` in `DATA_W`: per-bit write enable.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out `DATA_W`: read data.
- `RW_en` out 1: bank port enable.
- `RW_wmode` out 1: bank write mode.
- `RW_addr` out `ADDR_W`: bank address.
- `RW_wdata` out `DATA_W`: bank write data.
- `RW_wmask` out `DATA_W`: bank write mask.
- `RW_rdata` in `DATA_W`: bank read data (combinational from `RW_addr`).

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous, active-high. All flops clear immediately on `rst`.
- Reset values:
  - State = IDLE; `init_busy` = 0; `init_done` = 0.
  - `rsp_valid` = 0; `rsp_rdata` = 0.
  - Sweep counter = 0.
  - Memory-side outputs all 0 while `rst` is high.
  - Reset does not clear the bank contents.
- States: IDLE and INIT.
- IDLE:
  - `req_ready` = !`init_start` && (!`rsp_valid` || `rsp_ready`).
  - Fire = `req_valid` && `req_ready`.
  - On fire, bank outputs are driven combinationally the same cycle: `RW_en`=1, `RW_wmode`=`req_write`, `RW_addr`=`req_addr`, `RW_wdata`=`req_wdata`, `RW_wmask`=`req_wmask`.
  - Without fire: `RW_en`=0, `RW_wmode`=0, `RW_wmask`=0. `RW_addr` and `RW_wdata` hold the last driven values (registered shadow).
- Write: commits at the end of the fire cycle, only for bits where the mask is 1. No response is generated. Latency 1; a read fired in the next cycle returns the new data.
- Read:
  - `RW_rdata` is captured into `rsp_rdata` at the end of the fire cycle.
  - `rsp_valid`=1 from the next cycle and holds, with `rsp_rdata` stable, until `rsp_ready`.
  - Response buffer is one entry. `req_ready` gating guarantees no overflow.
  - Back-to-back reads at 1/cycle are sustained while `rsp_ready`=1.
- `rsp_valid` update each cycle:
  - Set by a read fire.
  - Else cleared by `rsp_ready`.
  - Read fire and `rsp_ready` in the same cycle: the new data replaces the old; `rsp_valid` stays 1.
- `init_start` in IDLE:
  - Go to INIT and clear the counter.
  - Any same-cycle request is NOT accepted (`req_ready` = 0).
  - A pending response is unaffected and may still drain during INIT.
- INIT:
  - `init_busy`=1; `req_ready`=0.
  - Each cycle: `RW_en`=1, `RW_wmode`=1, `RW_addr`=counter, `RW_wdata`=`INIT_VALUE`, `RW_wmask`=all ones; counter += 1.
  - After writing `DEPTH`-1: go to IDLE with `init_done`=1 for exactly one cycle (the first IDLE cycle).
  - Total of `DEPTH` write cycles. The first request can be accepted in the `init_done` cycle.
  - `init_start` during INIT is ignored (no restart).
- Counter width: `ADDR_W`+1 bits, so `DEPTH` = 2^`ADDR_W` terminates without wrap ambiguity.
- `rst` mid-INIT: the sweep aborts immediately and the bank is left partially initialised. The sweep does not restart automatically.
- `rst` mid-read: a captured response is lost.

Decomposition:
- Package `mem_bank_pkg`:
  - State enum `init_state_e` {IDLE, INIT}.
  - Default `ADDR_W`/`DATA_W`/`DEPTH` constants.
  - Packed struct `mem_req_t` {write, addr, wdata, wmask} shared with clients.
- Sub-module `mem_rsp_buffer`: single-entry valid/ready holding register with same-cycle replace. It is natural and reusable.
- The FSM, counter and port mux stay in the top module.

Test Plan:
- Reset, then `init_start` for 1 cycle:
  - `RW_en`/`RW_wmode`=1 for exactly 32 cycles with addresses 0..31, wdata 0, mask 0x3FF.
  - `init_done` pulses once; subsequent reads of addr 0, 17 and 31 return 0x000.
- Write addr 5 = 0x2AA mask 0x3FF, next cycle read addr 5:
  - `rsp_valid` appears the cycle after the read fire with `rsp_rdata`=0x2AA.
- Masked write addr 5 with wdata 0x155, mask 0x00F, then read:
  - `rsp_rdata`=0x2A5.
- Backpressure:
  - Read addr 1, then read addr 2 with `rsp_ready`=0 → `req_ready`=0 and the addr 1 data holds stable.
  - Raise `rsp_ready` → addr 2 is accepted the same cycle, addr 1 data is consumed, and addr 2 data follows next cycle.
- `init_start` and `req_valid` asserted in the same cycle:
  - Request is not accepted.
  - Second `init_start` mid-sweep is ignored (still exactly 32 writes).
  - Request is accepted in the `init_done` cycle.
- Assert `rst` at sweep address 10:
  - Outputs drop to 0 asynchronously and `init_busy`=0.
  - Addresses 0..9 read 0; address 20 retains its pre-sweep value.
